// File: rtl/snn_wta_pkg.sv
// Shared types and helpers for the windowed winner-take-all selector of the SNN output layer.
package snn_wta_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } wta_state_t;

    // argmax_lowest scans counts zero-extended into this fixed-size container.
    localparam int MAX_NODES = 64;
    localparam int MAX_CNT_W = 32;

    typedef logic [MAX_NODES-1:0][MAX_CNT_W-1:0] count_vec_t;

    typedef struct packed {
        logic [15:0]          idx;
        logic [MAX_CNT_W-1:0] cnt;
    } argmax_t;

    function automatic int idx_width(input int num_nodes);
        return (num_nodes <= 1) ? 1 : $clog2(num_nodes);
    endfunction

    function automatic int win_width(input int window_len);
        return (window_len <= 0) ? 1 : $clog2(window_len + 1);
    endfunction

    // Strict greater-than keeps the earliest index on ties; all-zero yields index 0.
    function automatic argmax_t argmax_lowest(input count_vec_t counts);
        argmax_t best;
        best.idx = '0;
        best.cnt = counts[0];
        for (int i = 1; i < MAX_NODES; i++) begin
            if (counts[i] > best.cnt) begin
                best.idx = 16'(i);
                best.cnt = counts[i];
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/winner_take_all_window_sat_counter.sv
// Saturating per-node spike counter; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/winner_take_all_window.sv
// Windowed winner-take-all: per-node spike counts, running leader with gated spike, per-window winner report.
//   state    | meaning
//   S_IDLE   | waiting for the first enabled sample of a window
//   S_COUNT  | accumulating enabled samples into the node counters
//   S_REPORT | one cycle: latch winner, clear counters, dead sample
module winner_take_all_window
    import snn_wta_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int CNT_W      = 16,
    parameter int WINDOW_LEN = 256,
    parameter int IDX_W      = idx_width(NUM_NODES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic [NUM_NODES-1:0] nodes_i,
    output logic                 spike_o,
    output logic [IDX_W-1:0]     leader_idx_o,
    output logic                 winner_valid_o,
    output logic [IDX_W-1:0]     winner_idx_o,
    output logic [CNT_W-1:0]     winner_cnt_o,
    output logic                 window_done_o
);

    localparam int               WIN_W    = win_width(WINDOW_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WINDOW_LEN > 0) ? WINDOW_LEN - 1 : 0);

    wta_state_t       r_state;
    logic [WIN_W-1:0] r_win_cnt;
    logic [IDX_W-1:0] r_leader;
    logic [IDX_W-1:0] r_winner_idx;
    logic [CNT_W-1:0] r_winner_cnt;
    logic             r_spike;
    logic             r_valid;

    logic             w_sample;
    logic             w_last;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_cnt [NUM_NODES];
    count_vec_t       w_counts_pad;
    argmax_t          w_arg;
    logic [IDX_W-1:0] w_arg_idx;
    logic [CNT_W-1:0] w_arg_cnt;

    // The IDLE->COUNT edge also counts its sample, so IDLE is a sampling state too.
    assign w_sample  = en_i && ((r_state == S_IDLE) || (r_state == S_COUNT));
    assign w_last    = w_sample && (WINDOW_LEN != 0) && (r_win_cnt == WIN_LAST);
    assign w_cnt_clr = clear_i || (r_state == S_REPORT);

    generate
        for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
            sat_counter #(
                .WIDTH (CNT_W)
            ) u_cnt (
                .i_clk   (clk_i),
                .i_rst   (rst_i),
                .i_inc   (w_sample && nodes_i[g]),
                .i_clr   (w_cnt_clr),
                .o_count (w_cnt[g])
            );
        end
    endgenerate

    always_comb begin
        w_counts_pad = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            w_counts_pad[i] = MAX_CNT_W'(w_cnt[i]);
        end
        w_arg     = argmax_lowest(w_counts_pad);
        w_arg_idx = IDX_W'(w_arg.idx);
        w_arg_cnt = CNT_W'(w_arg.cnt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= '0;
            r_leader     <= '0;
            r_spike      <= 1'b0;
            r_valid      <= 1'b0;
            r_winner_idx <= '0;
            r_winner_cnt <= '0;
        end else if (clear_i) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
            r_leader  <= '0;
            r_spike   <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_leader <= w_arg_idx;
            // Only a counted sample that keeps the window open forwards the leader's spike.
            r_spike  <= w_sample && !w_last && nodes_i[r_leader];

            if (w_last || (r_state == S_REPORT)) begin
                r_win_cnt <= '0;
            end else if (w_sample && (WINDOW_LEN != 0)) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (en_i) begin
                        r_state <= w_last ? S_REPORT : S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_last) begin
                        r_state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_state      <= en_i ? S_COUNT : S_IDLE;
                    r_leader     <= '0;
                    r_winner_idx <= w_arg_idx;
                    r_winner_cnt <= w_arg_cnt;
                    r_valid      <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spike_o        = r_spike;
    assign leader_idx_o   = r_leader;
    assign winner_valid_o = r_valid;
    assign winner_idx_o   = r_winner_idx;
    assign winner_cnt_o   = r_winner_cnt;
    assign window_done_o  = (r_state == S_REPORT);

endmodule
